// File: rtl/dispense_pulse_driver.sv
// Turns single-cycle dispense requests into timed actuator pulses.
// Each pulse has a fixed on-time followed by a guard gap; extra requests wait in a saturating queue.
module dispense_pulse_driver #(
  parameter int ON_CYCLES   = 10_000_000,
  parameter int OFF_CYCLES  = 5_000_000,
  parameter int MAX_PENDING = 7,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          abort,
  output logic          drive,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GUARD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pend_d;
  logic          done_d;
  logic          ovf_d;
  logic          queue_req;
  logic          last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drive    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      pending  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drive    <= (state_d == ON);
      done     <= done_d;
      overflow <= ovf_d;
      pending  <= pend_d;
    end
  end

  // A request that does not start a pulse this cycle is queued (or dropped when full).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pending;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    queue_req = 1'b0;
    last      = (cnt_q == '0);

    case (state_q)
      IDLE: begin
        if (req && !abort) begin
          state_d = ON;
          cnt_d   = ON_LOAD;
        end
      end
      ON: begin
        if (abort) begin
          state_d = GUARD;
          cnt_d   = OFF_LOAD;
          pend_d  = '0;
        end else begin
          queue_req = req;
          if (last) begin
            state_d = GUARD;
            cnt_d   = OFF_LOAD;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      GUARD: begin
        if (abort) begin
          pend_d = '0;
          if (last) state_d = IDLE;
          else      cnt_d   = cnt_q - CW'(1);
        end else if (last) begin
          if (pending != '0) begin
            // A same-cycle request refills the slot just taken, so the count holds.
            state_d = ON;
            cnt_d   = ON_LOAD;
            if (!req) pend_d = pending - PW'(1);
          end else if (req) begin
            state_d = ON;
            cnt_d   = ON_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          queue_req = req;
          cnt_d     = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (queue_req) begin
      if (pending == PEND_MAX) ovf_d  = 1'b1;
      else                     pend_d = pending + PW'(1);
    end
  end

  assign busy = (state_q != IDLE) || (pending != '0);

endmodule

// File: tb/tb_dispense_pulse_driver.sv
// Bench for dispense_pulse_driver: directed scenarios plus random traffic against
// a time-window reference model (pulse start/end and guard end as absolute cycles).
module tb_dispense_pulse_driver;

  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int MAX = 2;
  localparam int PW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          abort;
  logic          drive;
  logic          busy;
  logic          done;
  logic [PW-1:0] pending;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  int cyc;

  int   on_start, on_end, guard_end, pend;
  logic m_done, m_ovf;

  dispense_pulse_driver #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .MAX_PENDING(MAX)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .abort   (abort),
    .drive   (drive),
    .busy    (busy),
    .done    (done),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [PW+3:0] obs();
    return {drive, busy, done, overflow, pending};
  endfunction

  // Expected outputs for the cycle currently observed (cyc).
  function automatic logic [PW+3:0] model_out();
    logic e_drive, e_busy;
    e_drive = (cyc >= on_start) && (cyc <= on_end);
    e_busy  = (cyc <= guard_end) || (pend != 0);
    return {e_drive, e_busy, m_done, m_ovf, PW'(pend)};
  endfunction

  task automatic start_pulse(input int n);
    on_start  = n;
    on_end    = n + ON - 1;
    guard_end = n + ON + OFF - 1;
  endtask

  task automatic enqueue();
    if (pend == MAX) m_ovf = 1'b1;
    else             pend++;
  endtask

  // t is the cycle whose inputs were just sampled; results belong to t+1.
  task automatic model_step(input logic r, input logic a, input logic rs);
    int t;
    t      = cyc;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    if (rs) begin
      on_start = -100; on_end = -100; guard_end = -100; pend = 0;
    end else if (t <= on_end) begin
      if (a) begin
        on_end    = t;
        guard_end = t + OFF;
        pend      = 0;
      end else begin
        if (r) enqueue();
        if (t == on_end) m_done = 1'b1;
      end
    end else if (t <= guard_end) begin
      if (a) pend = 0;
      else if (t == guard_end && pend > 0) begin
        pend--;
        start_pulse(t + 1);
        if (r) enqueue();
      end else if (t == guard_end && r) start_pulse(t + 1);
      else if (r) enqueue();
    end else if (r && !a) begin
      start_pulse(t + 1);
    end
  endtask

  task automatic run_cycle(input logic r, input logic a, input logic rs);
    req   = r;
    abort = a;
    reset = rs;
    @(posedge clk);
    model_step(r, a, rs);
    cyc++;
    @(negedge clk);
    req   = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  task automatic preamble();
    cyc = 0;
    for (int c = 0; c < 10; c++) run_cycle(1'b0, 1'b0, c <= 2);
  endtask

  task automatic test_reset();
    cyc = 0;
    for (int c = 0; c < 10; c++) begin
      run_cycle(1'b0, 1'b0, c <= 2);
      total++;
      if (obs() !== '0) begin
        bad++;
        $display("[TB] FAIL reset_idle cycle %0d: got %b want %b", cyc, obs(), {(PW+4){1'b0}});
      end
      total++;
      if (obs() !== model_out()) begin
        bad++;
        $display("[TB] FAIL reset_model cycle %0d: got %b want %b", cyc, obs(), model_out());
      end
    end
  endtask

  task automatic test_single();
    logic [2:0] want;
    preamble();
    for (int c = 10; c <= 20; c++) begin
      run_cycle(c == 10, 1'b0, 1'b0);
      want = {(cyc >= 11 && cyc <= 14), (cyc >= 11 && cyc <= 17), (cyc == 15)};
      total++;
      if ({drive, busy, done} !== want) begin
        bad++;
        $display("[TB] FAIL single_pulse cycle %0d: got %b want %b", cyc, {drive, busy, done}, want);
      end
      total++;
      if (obs() !== model_out()) begin
        bad++;
        $display("[TB] FAIL single_model cycle %0d: got %b want %b", cyc, obs(), model_out());
      end
    end
  endtask

  task automatic test_overflow();
    logic [2:0]    want;
    logic [PW-1:0] want_p;
    preamble();
    for (int c = 10; c <= 33; c++) begin
      run_cycle(c >= 10 && c <= 13, 1'b0, 1'b0);
      want = {((cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21) || (cyc >= 25 && cyc <= 28)),
              (cyc == 15 || cyc == 22 || cyc == 29), (cyc == 14)};
      total++;
      if ({drive, done, overflow} !== want) begin
        bad++;
        $display("[TB] FAIL queue_pulses cycle %0d: got %b want %b", cyc, {drive, done, overflow}, want);
      end
      if (cyc >= 12 && cyc <= 14) begin
        want_p = (cyc == 12) ? PW'(1) : PW'(2);
        total++;
        if (pending !== want_p) begin
          bad++;
          $display("[TB] FAIL queue_pending cycle %0d: got %0d want %0d", cyc, pending, want_p);
        end
      end
      total++;
      if (obs() !== model_out()) begin
        bad++;
        $display("[TB] FAIL queue_model cycle %0d: got %b want %b", cyc, obs(), model_out());
      end
    end
  endtask

  task automatic test_abort();
    logic [2:0] want;
    preamble();
    for (int c = 10; c <= 18; c++) begin
      run_cycle(c == 10 || c == 11, c == 12, 1'b0);
      if (cyc >= 13) begin
        want = {1'b0, 1'b0, (cyc <= 15)};
        total++;
        if ({drive, done, busy} !== want || (cyc == 13 && pending !== '0)) begin
          bad++;
          $display("[TB] FAIL abort_flush cycle %0d: got %b/%0d want %b/0", cyc, {drive, done, busy},
                   pending, want);
        end
      end
      total++;
      if (obs() !== model_out()) begin
        bad++;
        $display("[TB] FAIL abort_model cycle %0d: got %b want %b", cyc, obs(), model_out());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    preamble();
    for (int c = 10; c <= 28; c++) begin
      run_cycle(c == 10 || c == 17, 1'b0, 1'b0);
      want = {((cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21)), (cyc >= 11 && cyc <= 24)};
      total++;
      if ({drive, busy} !== want || pending !== '0) begin
        bad++;
        $display("[TB] FAIL back_to_back cycle %0d: got %b/%0d want %b/0", cyc, {drive, busy}, pending,
                 want);
      end
      total++;
      if (obs() !== model_out()) begin
        bad++;
        $display("[TB] FAIL b2b_model cycle %0d: got %b want %b", cyc, obs(), model_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic want;
    preamble();
    for (int c = 10; c <= 27; c++) begin
      run_cycle(c == 10 || c == 20, 1'b0, c == 12);
      want = (cyc >= 11 && cyc <= 12) || (cyc >= 21 && cyc <= 24);
      total++;
      if (drive !== want || (cyc == 13 && busy !== 1'b0)) begin
        bad++;
        $display("[TB] FAIL reset_mid cycle %0d: got drive=%b busy=%b want drive=%b", cyc, drive, busy,
                 want);
      end
      total++;
      if (obs() !== model_out()) begin
        bad++;
        $display("[TB] FAIL reset_mid_model cycle %0d: got %b want %b", cyc, obs(), model_out());
      end
    end
  endtask

  task automatic test_random();
    logic r, a, rs;
    preamble();
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 99) < 45);
      a  = ($urandom_range(0, 99) < 4);
      rs = ($urandom_range(0, 999) < 5);
      run_cycle(r, a, rs);
      total++;
      if (obs() !== model_out()) begin
        bad++;
        $display("[TB] FAIL random_model cycle %0d: got %b want %b", cyc, obs(), model_out());
      end
    end
  endtask

  initial begin
    req       = 1'b0;
    abort     = 1'b0;
    reset     = 1'b1;
    on_start  = -100;
    on_end    = -100;
    guard_end = -100;
    pend      = 0;
    m_done    = 1'b0;
    m_ovf     = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispense_pulse_driver.md
# dispense_pulse_driver

Output-side counterpart to the button debouncers: converts single-cycle dispense requests from the vending FSM into timed drive pulses for a solenoid or motor.
- Each pulse holds `drive` high for a fixed on-time, then enforces a guard (off) time before the next pulse.
- Requests arriving while busy are queued in a saturating pending counter; overflowing requests are dropped and flagged.
- Sits between the vending controller FSM and the physical actuator pin.

## Interface
Parameters:
- `ON_CYCLES`, 10_000_000, clock cycles `drive` is held high per pulse (>=1)
- `OFF_CYCLES`, 5_000_000, guard cycles with `drive` low after each pulse (>=1)
- `MAX_PENDING`, 7, maximum queued requests (>=1); `pending` width = clog2(MAX_PENDING+1)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  1  one-cycle dispense request
- `abort`  in  1  one-cycle cancel: ends current pulse, flushes queue
- `drive`  out  1  registered actuator drive
- `busy`  out  1  high when state != IDLE or pending != 0
- `done`  out  1  one-cycle pulse after a pulse completes its full on-time
- `pending`  out  PW  queued requests not yet started
- `overflow`  out  1  one-cycle pulse when a request is dropped

## Operation
- States: IDLE, ON, GUARD. One down-counter sized for max(ON_CYCLES, OFF_CYCLES).
- Reset: state IDLE, counter 0, `drive`=0, `done`=0, `overflow`=0, `pending`=0, `busy`=0.
- IDLE: `req` -> ON next cycle and load counter with ON_CYCLES-1; `pending` unchanged.
- ON: `drive`=1. On the last cycle (counter=0) -> GUARD and load OFF_CYCLES-1; `done` pulses on the first GUARD cycle.
- GUARD: `drive`=0. On the last cycle:
  - `pending`>0 -> ON and decrement `pending`.
  - else `req` this cycle -> ON directly; `pending` stays 0.
  - else -> IDLE.
- `req` in any non-IDLE cycle not consumed as above increments `pending`.
- If `pending`=MAX_PENDING when such a `req` arrives, the request is dropped, `overflow` pulses the next cycle, and `pending` holds.
- On the last GUARD cycle with `pending`>0 and `req` also high, the pending count is unchanged (net +1 -1).
- `abort` has priority over `req`; a `req` in the same cycle is ignored.
  - In ON: -> GUARD next cycle with full OFF_CYCLES reload, `drive` low, `pending`=0, no `done`.
  - In GUARD: `pending`=0; guard continues to completion.
  - In IDLE: no effect.
- `reset` overrides everything, including mid-pulse: `drive` low the cycle after reset is sampled.

## Timing
- `req` at cycle t from IDLE: `drive` high t+1 .. t+ON_CYCLES; GUARD t+ON_CYCLES+1 .. t+ON_CYCLES+OFF_CYCLES.
- `done` is high at t+ON_CYCLES+1.
- Next pulse start (queued or same-cycle `req`) is at t+ON_CYCLES+OFF_CYCLES+1, so the minimum pulse period is exactly ON_CYCLES+OFF_CYCLES.
- `drive` never has a low gap shorter than OFF_CYCLES, including after an abort.
- `pending` and `overflow` are registered; both are visible one cycle after the triggering `req`.
- `busy` is combinational from registered state and `pending` only, with no input paths.

## Test plan
Parameters for all scenarios: ON_CYCLES=4, OFF_CYCLES=3, MAX_PENDING=2.
- Reset held cycles 0-2, idle inputs -> `drive`, `busy`, `done`, `overflow` = 0 and `pending`=0 through cycle 10.
- Single `req` at cycle 10 -> `drive` high 11-14, `done` at 15, `busy` high 11-17, IDLE at 18.
- `req` at cycles 10, 11, 12, 13 -> `pending` 1 at 12, 2 at 13; `overflow` at 14 with `pending` holding 2; `drive` high 11-14, 18-21, 25-28; three `done` pulses (15, 22, 29).
- `req` at 10 and 11, `abort` at 12 -> `drive` low from 13, `pending`=0 at 13, no `done`, GUARD 13-15, IDLE at 16.
- `req` at 10, then `req` at 17 (last GUARD cycle) -> `drive` high 18-21 with no IDLE cycle in between; `pending` stays 0.
- `req` at 10, `reset` at 12 -> `drive`=0 and `busy`=0 at 13; new `req` at 20 -> `drive` high 21-24.
